// File: rtl/booth_multiplier_seq_pkg.sv
// Shared arithmetic definitions for the sequential Booth multiplier:
// default operand width, FSM state encoding and Booth pair decoding.
package booth_multiplier_seq_pkg;

    // Default operand width in bits.
    localparam int unsigned DefaultWidth = 32;

    // FSM state encoding; values are fixed so other blocks can decode them.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } booth_state_e;

    // Action selected by one radix-2 Booth pair {Q[0], Q(-1)}.
    typedef enum logic [1:0] {
        OpNone = 2'd0,
        OpAdd  = 2'd1,
        OpSub  = 2'd2
    } booth_op_e;

    // 01 closes a run of ones (add), 10 opens one (subtract), 00/11 sit inside a run.
    function automatic booth_op_e booth_decode(input logic [1:0] pair);
        booth_op_e op;
        unique case (pair)
            2'b01:   op = OpAdd;
            2'b10:   op = OpSub;
            default: op = OpNone;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_multiplier_seq_booth_step.sv
// One combinational radix-2 Booth step: conditional add/subtract of the
// multiplicand into the accumulator, then an arithmetic right shift of {A,Q,Q(-1)}.
module booth_step
    import booth_multiplier_seq_pkg::*;
#(
    parameter int unsigned STEP_WIDTH = DefaultWidth + 1
) (
    input  logic [STEP_WIDTH-1:0] a,
    input  logic [STEP_WIDTH-1:0] q,
    input  logic                  q_m1,
    input  logic [STEP_WIDTH-1:0] m,
    output logic [STEP_WIDTH-1:0] a_next,
    output logic [STEP_WIDTH-1:0] q_next,
    output logic                  q_m1_next
);

    logic [STEP_WIDTH-1:0] sum;

    // Add, subtract or pass the accumulator according to the scanned pair.
    always_comb begin
        sum = a;
        unique case (booth_decode({q[0], q_m1}))
            OpAdd:   sum = a + m;
            OpSub:   sum = a - m;
            default: sum = a;
        endcase
    end

    // Arithmetic right shift of the concatenation {sum, q, q_m1} by one bit.
    always_comb begin
        a_next    = {sum[STEP_WIDTH-1], sum[STEP_WIDTH-1:1]};
        q_next    = {sum[0], q[STEP_WIDTH-1:1]};
        q_m1_next = q[0];
    end

endmodule

// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth multiplier. Operands are extended by one bit so the
// same datapath handles signed and unsigned products; one Booth step runs per
// BUSY cycle and WIDTH+1 steps produce the full product in {A,Q}.
module booth_multiplier_seq
    import booth_multiplier_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   in_1,
    input  logic [WIDTH-1:0]   in_2,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out
);

    localparam int unsigned ExtWidth = WIDTH + 1;
    localparam int unsigned CntWidth = $clog2(WIDTH + 2);
    // Counter value during the final Booth step (steps are numbered from 0).
    localparam logic [CntWidth-1:0] LastStep = CntWidth'(WIDTH);

    booth_state_e         state_q;
    logic [CntWidth-1:0]  cnt_q;
    logic [ExtWidth-1:0]  a_q;
    logic [ExtWidth-1:0]  q_q;
    logic [ExtWidth-1:0]  m_q;
    logic                 q_m1_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic [2*WIDTH-1:0]   out_q;

    logic [ExtWidth-1:0]  in_1_ext;
    logic [ExtWidth-1:0]  in_2_ext;
    logic [ExtWidth-1:0]  a_next;
    logic [ExtWidth-1:0]  q_next;
    logic                 q_m1_next;
    logic [2*WIDTH-1:0]   prod_low;

    // Sign- or zero-extend operands by one bit according to the requested mode.
    always_comb begin
        in_1_ext = {in_signed & in_1[WIDTH-1], in_1};
        in_2_ext = {in_signed & in_2[WIDTH-1], in_2};
    end

    booth_step #(
        .STEP_WIDTH (ExtWidth)
    ) u_booth_step (
        .a         (a_q),
        .q         (q_q),
        .q_m1      (q_m1_q),
        .m         (m_q),
        .a_next    (a_next),
        .q_next    (q_next),
        .q_m1_next (q_m1_next)
    );

    // Low 2*WIDTH bits of {A,Q} after the step; the two top bits are pure extension.
    always_comb begin
        prod_low = {a_next[WIDTH-2:0], q_next};
    end

    // FSM, datapath registers and registered handshake/product outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            a_q         <= '0;
            q_q         <= '0;
            m_q         <= '0;
            q_m1_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (flush) begin
            // Abort wins over accept and over the output handshake.
            state_q     <= StIdle;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        state_q    <= StBusy;
                        cnt_q      <= '0;
                        a_q        <= '0;
                        q_q        <= in_1_ext;
                        m_q        <= in_2_ext;
                        q_m1_q     <= 1'b0;
                        in_ready_q <= 1'b0;
                    end
                end
                StBusy: begin
                    a_q    <= a_next;
                    q_q    <= q_next;
                    q_m1_q <= q_m1_next;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LastStep) begin
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                        out_q       <= prod_low;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Self-checking bench for booth_multiplier_seq (WIDTH=32): directed corner
// products, randomized products against an arithmetic model, backpressure,
// flush, mid-operation reset and back-to-back traffic.
module tb_booth_multiplier_seq;

    localparam int unsigned W = 32;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic           in_signed;
    logic [W-1:0]   in_1;
    logic [W-1:0]   in_2;
    logic           flush;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out;

    int pass_cnt  = 0;
    int total_cnt = 0;

    booth_multiplier_seq #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .in_1      (in_1),
        .in_2      (in_2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: extend per mode to 128 bits, multiply, keep the low 2*W bits.
    function automatic logic [2*W-1:0] model(input bit s, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [127:0] ea;
        logic [127:0] eb;
        logic [127:0] p;
        ea = s ? {{(128-W){a[W-1]}}, a} : {{(128-W){1'b0}}, a};
        eb = s ? {{(128-W){b[W-1]}}, b} : {{(128-W){1'b0}}, b};
        p  = ea * eb;
        return p[2*W-1:0];
    endfunction

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = '1;
            2:       v = 32'h8000_0000;
            3:       v = 32'h7FFF_FFFF;
            4:       v = 32'h0000_0001;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Drive one operation, measure accept-to-out_valid latency, then consume.
    task automatic run_op(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [2*W-1:0] res, output int lat, output bit to);
        int guard;
        to    = 1'b0;
        lat   = 0;
        res   = '0;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            to = 1'b1;
            return;
        end
        in_signed = s;
        in_1      = a;
        in_2      = b;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        while (1) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
            if (lat > 200) begin
                to = 1'b1;
                return;
            end
        end
        res       = out;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_signed = 1'b0;
        in_1      = '0;
        in_2      = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #12;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (out !== '0) $display("FAIL reset_out: got %h want 0", out);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        bit             s_tab [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [W-1:0]   a_tab [5] = '{32'd12, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF,
                                      32'h8000_0000};
        logic [W-1:0]   b_tab [5] = '{32'd13, 32'h0000_0005, 32'h0000_0005, 32'hFFFF_FFFF,
                                      32'h8000_0000};
        logic [2*W-1:0] e_tab [5] = '{64'h0000_0000_0000_009C, 64'hFFFF_FFFF_FFFF_FFDD,
                                      64'h0000_0004_FFFF_FFDD, 64'hFFFF_FFFE_0000_0001,
                                      64'h4000_0000_0000_0000};
        logic [2*W-1:0] res;
        int             lat;
        bit             to;
        for (int i = 0; i < 5; i++) begin
            run_op(s_tab[i], a_tab[i], b_tab[i], res, lat, to);
            total_cnt++;
            if (to || res !== e_tab[i])
                $display("FAIL directed_%0d: got %h want %h (timeout=%0d)", i, res, e_tab[i], to);
            else pass_cnt++;
            total_cnt++;
            if (lat !== W + 1) $display("FAIL latency_%0d: got %0d want %0d", i, lat, W + 1);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [2*W-1:0] res;
        logic [2*W-1:0] exp;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        bit             s;
        int             lat;
        bit             to;
        for (int i = 0; i < 40; i++) begin
            s   = 1'($urandom_range(0, 1));
            a   = pick_operand();
            b   = pick_operand();
            exp = model(s, a, b);
            run_op(s, a, b, res, lat, to);
            total_cnt++;
            if (to || res !== exp)
                $display("FAIL random_%0d: s=%0d a=%h b=%h got %h want %h", i, s, a, b, res, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        logic [2*W-1:0] held;
        logic [2*W-1:0] exp;
        int             guard;
        bit             seen;
        exp = model(1'b1, 32'hFFFF_FF00, 32'h0000_1234);
        @(negedge clk);
        in_signed = 1'b1;
        in_1      = 32'hFFFF_FF00;
        in_2      = 32'h0000_1234;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        total_cnt++;
        if (!out_valid || out !== exp)
            $display("FAIL bp_result: got %h valid=%b want %h", out, out_valid, exp);
        else pass_cnt++;
        held      = out;
        in_signed = 1'b0;
        in_1      = 32'd3;
        in_2      = 32'd7;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total_cnt++;
            if (out_valid !== 1'b1 || out !== held || in_ready !== 1'b0)
                $display("FAIL bp_hold_%0d: valid=%b ready=%b out=%h want 1/0/%h",
                         i, out_valid, in_ready, out, held);
            else pass_cnt++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        total_cnt++;
        if (seen) $display("FAIL bp_no_capture: got out_valid=1 want 0");
        else pass_cnt++;
    endtask

    task automatic test_flush();
        logic [2*W-1:0] res;
        int             lat;
        bit             to;
        bit             seen;
        // Flush in BUSY after 10 steps, with in_valid asserted alongside.
        @(negedge clk);
        in_signed = 1'b0;
        in_1      = 32'hDEAD_BEEF;
        in_2      = 32'h1234_5678;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL flush_busy: ready=%b valid=%b want 1/0", in_ready, out_valid);
        else pass_cnt++;
        seen = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        total_cnt++;
        if (seen) $display("FAIL flush_no_result: got out_valid=1 want 0");
        else pass_cnt++;
        run_op(1'b0, 32'd46, 32'd50, res, lat, to);
        total_cnt++;
        if (to || res !== 64'h8FC) $display("FAIL flush_next: got %h want %h", res, 64'h8FC);
        else pass_cnt++;
        // Flush in IDLE beats a simultaneous accept.
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL flush_idle: got in_ready=%b want 1", in_ready);
        else pass_cnt++;
        // Flush in DONE beats a simultaneous output handshake and discards the result.
        @(negedge clk);
        in_signed = 1'b0;
        in_1      = 32'd9;
        in_2      = 32'd9;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (W + 2) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b1 || out !== 64'd81)
            $display("FAIL flush_done_pre: valid=%b out=%h want 1/%h", out_valid, out, 64'd81);
        else pass_cnt++;
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flush_done: valid=%b ready=%b want 0/1", out_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [2*W-1:0] res;
        int             lat;
        bit             to;
        bit             seen;
        @(negedge clk);
        in_signed = 1'b1;
        in_1      = 32'h8765_4321;
        in_2      = 32'h1357_9BDF;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== '0)
            $display("FAIL reset_mid: ready=%b valid=%b out=%h want 1/0/0",
                     in_ready, out_valid, out);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        total_cnt++;
        if (seen) $display("FAIL reset_mid_spurious: got out_valid=1 want 0");
        else pass_cnt++;
        run_op(1'b1, 32'hFFFF_FFFF, 32'd2, res, lat, to);
        total_cnt++;
        if (to || res !== 64'hFFFF_FFFF_FFFF_FFFE)
            $display("FAIL reset_mid_next: got %h want %h", res, 64'hFFFF_FFFF_FFFF_FFFE);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] exp_q [$];
        logic [2*W-1:0] exp;
        int             issued;
        int             done;
        int             cycles;
        bit             s;
        issued    = 0;
        done      = 0;
        cycles    = 0;
        out_ready = 1'b1;
        while (done < 4 && cycles < 400) begin
            @(negedge clk);
            cycles++;
            if (out_valid) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                total_cnt++;
                if (out !== exp) $display("FAIL b2b_%0d: got %h want %h", done, out, exp);
                else pass_cnt++;
                done++;
            end
            if (in_ready && issued < 4) begin
                s         = 1'($urandom_range(0, 1));
                in_signed = s;
                in_1      = pick_operand();
                in_2      = pick_operand();
                in_valid  = 1'b1;
                exp_q.push_back(model(s, in_1, in_2));
                issued++;
            end else if (in_ready) begin
                in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total_cnt++;
        if (done !== 4) $display("FAIL b2b_count: got %0d results want 4", done);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/booth_multiplier_seq.md
BOOTH_MULTIPLIER_SEQ -- requirements
Module: booth_multiplier_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width in bits (legal range 4..64).
REQ-002 SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit, meaning operands and mode are valid.
REQ-005 SHALL have port in_ready, output, 1 bit, meaning the block can accept operands.
REQ-006 SHALL have port in_signed, input, 1 bit, meaning 1 = two's-complement operands, 0 = unsigned operands.
REQ-007 SHALL have port in_1, input, WIDTH bits, meaning the multiplier (Booth-scanned operand).
REQ-008 SHALL have port in_2, input, WIDTH bits, meaning the multiplicand.
REQ-009 SHALL have port flush, input, 1 bit, meaning synchronous abort of any operation in progress.
REQ-010 SHALL have port out_valid, output, 1 bit, meaning out holds a finished product.
REQ-011 SHALL have port out_ready, input, 1 bit, meaning the consumer accepts out.
REQ-012 SHALL have port out, output, 2*WIDTH bits, meaning product in_1*in_2, interpreted per the captured mode.

Function
REQ-013 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; SHALL drive out_valid=1 only in DONE.
REQ-015 SHALL, in IDLE with in_valid=1, capture in_1, in_2 and in_signed at the rising edge, clear the step counter, and enter BUSY.
REQ-016 SHALL extend both operands to WIDTH+1 bits: sign-extend when in_signed=1, zero-extend when in_signed=0.
REQ-017 SHALL hold state as an accumulator A of WIDTH+1 bits, cleared on accept, a Q register containing the extended in_1, and a Q(-1) bit cleared on accept.
REQ-018 SHALL perform exactly one radix-2 Booth step per BUSY cycle, using the pair {Q[0],Q(-1)}:
- 01: A += M.
- 10: A -= M.
- 00 or 11: A unchanged.
- Then an arithmetic right shift of {A,Q,Q(-1)} by one bit.
REQ-019 SHALL perform exactly WIDTH+1 steps and enter DONE on the edge that completes the final step, so out_valid rises WIDTH+1 cycles after the accepting edge (33 for WIDTH=32).
REQ-020 SHALL present out as the low 2*WIDTH bits of {A,Q} and hold out stable for the whole time the block is in DONE.
REQ-021 SHALL remain in DONE while out_ready=0, and return to IDLE on the edge where out_valid=1 and out_ready=1.
REQ-022 SHALL ignore in_valid in BUSY and DONE; operands presented there are not captured.
REQ-023 SHALL, when flush=1, enter IDLE at the next edge from any state, discarding any partial or unconsumed result.
REQ-024 SHALL give flush priority over every other transition, including a simultaneous accept in IDLE or a simultaneous out handshake in DONE.
REQ-025 SHALL produce bit-exact products for all operand values, including the most negative signed value and all-ones unsigned operands.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force:
- state = IDLE;
- in_ready = 1 (once rst_n deasserts);
- out_valid = 0;
- out = 0;
- step counter, A, Q and Q(-1) all = 0.
REQ-027 SHALL, when reset is asserted mid-operation, discard the operation and produce no out_valid for it after reset release.

Structure
REQ-028 SHALL take the FSM state encoding (IDLE=0, BUSY=1, DONE=2) and the default WIDTH constant from the shared arithmetic package.
REQ-029 SHALL place the combinational Booth add/subtract/shift of REQ-018 in one sub-module, booth_step, parameterised by WIDTH+1.
REQ-030 SHALL size the step counter to clog2(WIDTH+2) bits.

Verification (WIDTH=32)
REQ-031 SHALL cover: unsigned 12 x 13 -> out=0x000000000000009C, with out_valid rising 33 cycles after accept.
REQ-032 SHALL cover: signed 0xFFFFFFF9 x 0x00000005 -> out=0xFFFFFFFFFFFFFFDD; the same operands unsigned -> out=0x00000004FFFFFFDD.
REQ-033 SHALL cover: unsigned 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE00000001; signed 0x80000000 x 0x80000000 -> 0x4000000000000000.
REQ-034 SHALL cover backpressure: out_ready held 0 for 10 cycles in DONE -> out stable, in_ready=0 throughout, and a new in_valid is not captured.
REQ-035 SHALL cover flush at BUSY step 10 together with in_valid=1 -> IDLE next cycle, no out_valid, and the next accepted 46 x 50 -> 0x8FC.
REQ-036 SHALL cover rst_n pulsed low at BUSY step 5 -> all outputs at reset values immediately, and no spurious out_valid after release.
